breakout_bounce_gen: RTL

Synthesizable button-chatter emulator, the transmitter end of the button-debounce path. It accepts a clean "drive button to level X" request and emits a bouncing waveform on btn_out: pseudo-random toggles, then a settled level held for a fixed time. One instance drives each of the left/right/start inputs of the debouncer, for on-board self-test and for simulation.

---
 rtl/breakout_pkg.sv | 21 ++
 rtl/breakout_lfsr16.sv | 24 ++
 rtl/breakout_bounce_gen.sv | 128 ++++++++++++
 3 files changed

// File: rtl/breakout_pkg.sv
// rtl/breakout_pkg.sv - shared types and constants for the breakout button path
package breakout_pkg;

    // Bounce generator sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        HOLD   = 2'd2,
        DONE   = 2'd3
    } bounce_state_t;

    // Galois feedback taps for the 16-bit LFSR
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    // Power-on LFSR contents when the instantiator does not choose one
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // Settle window shared by the debouncer and the chatter emulator
    localparam int DEBOUNCE_CYCLES = 10000;

endpackage

// File: rtl/breakout_lfsr16.sv
// rtl/breakout_lfsr16.sv - free-running 16-bit Galois LFSR with parameterised seed
module breakout_lfsr16
    import breakout_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] state
);

    // An all-zero state would lock the LFSR, so a zero seed is nudged to 1
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    // Shift right every clock, folding the taps in when a one falls out
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SEED_EFF;
        end else begin
            state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_MASK : 16'h0000);
        end
    end

endmodule

// File: rtl/breakout_bounce_gen.sv
// rtl/breakout_bounce_gen.sv - button chatter emulator; BOUNCE_GEN_DETERMINISTIC_EN fixes bounce count and gap
module breakout_bounce_gen
    import breakout_pkg::*;
#(
    parameter int          BOUNCE_MAX  = 5,
    parameter int          GAP_MIN     = 250,
    parameter int          GAP_BITS    = 8,
    parameter int          HOLD_CYCLES = DEBOUNCE_CYCLES,
    parameter logic [15:0] LFSR_SEED   = LFSR_DEFAULT_SEED
) (
    input  logic clk,
    input  logic reset,
    input  logic req_valid,
    input  logic req_level,
    output logic req_ready,
    output logic btn_out,
    output logic busy,
    output logic done
);

    // Gap counter holds gap-1, at most GAP_MIN + 2^GAP_BITS - 2
    localparam int GW = $clog2(GAP_MIN + (1 << GAP_BITS));
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [2:0]    BMAX      = 3'(BOUNCE_MAX);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    bounce_state_t state;
    logic [15:0]   lfsr_q;
    logic [GW-1:0] gap_cnt;
    logic [HW-1:0] hold_cnt;
    logic [3:0]    toggles_left;
    logic [2:0]    k_load;
    logic [GW-1:0] gap_load;
    logic          unused_lfsr_bits;

    breakout_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .state (lfsr_q)
    );

    // Not every LFSR bit steers timing; reduce the rest into a sink
    assign unused_lfsr_bits = ^lfsr_q;

    // Bounce pair count and next gap (minus one), both drawn from the current LFSR state
    always_comb begin
        k_load   = BMAX;
        gap_load = GW'(GAP_MIN - 1);
`ifdef BOUNCE_GEN_DETERMINISTIC_EN
        k_load   = BMAX;
        gap_load = GW'(GAP_MIN - 1);
`else
        k_load   = (lfsr_q[2:0] > BMAX) ? BMAX : lfsr_q[2:0];
        gap_load = GW'(GAP_MIN - 1) + GW'(lfsr_q[GAP_BITS-1:0]);
`endif
    end

    // Request sequencer: first toggle on acceptance, 2k further toggles, hold, one-cycle done
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            btn_out      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            req_ready    <= 1'b1;
            gap_cnt      <= '0;
            hold_cnt     <= '0;
            toggles_left <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                        if (req_level != btn_out) begin
                            btn_out <= req_level;
                            if (k_load != 3'd0) begin
                                state        <= BOUNCE;
                                toggles_left <= {k_load, 1'b0};
                                gap_cnt      <= gap_load;
                            end else begin
                                state    <= HOLD;
                                hold_cnt <= HOLD_LOAD;
                            end
                        end else begin
                            state    <= HOLD;
                            hold_cnt <= HOLD_LOAD;
                        end
                    end
                end
                BOUNCE: begin
                    if (gap_cnt == '0) begin
                        btn_out      <= ~btn_out;
                        toggles_left <= toggles_left - 4'd1;
                        if (toggles_left == 4'd1) begin
                            state    <= HOLD;
                            hold_cnt <= HOLD_LOAD;
                        end else begin
                            gap_cnt <= gap_load;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
